alarm_timekeeper: RTL and testbench
===================================

Name: alarm_timekeeper

Overview:
Time-of-day and alarm core for the alarm clock. It derives a 1 Hz tick from the board clock and keeps BCD HH:MM:SS. It also holds a settable HH:MM alarm and drives the buzzer with a square tone when the alarm fires. It sits directly upstream of the 7-segment display multiplexer, which consumes hh_bcd/mm_bcd/ss_bcd as ready-made BCD digits.

Parameters:
CLK_HZ, 50000000, input clock frequency; the prescaler wraps at CLK_HZ-1.
TONE_HZ, 2000, buzzer tone frequency; half-period is CLK_HZ/(2*TONE_HZ) cycles, integer division.
ALARM_SEC, 60, number of 1 Hz ticks the alarm rings before it self-clears.

Ports:
clk  in  1  system clock.
rst  in  1  reset: asynchronous, active-high.
btn_mode  in  1  single-cycle pulse, already debounced upstream; advances the mode.
btn_inc  in  1  single-cycle pulse, already debounced; increments the field being edited.
alarm_en  in  1  level; the alarm is armed while high.
hh_bcd  out  8  hours in BCD, {tens,units}; shows the alarm hours in ALM_HR/ALM_MIN.
mm_bcd  out  8  minutes in BCD; shows the alarm minutes in ALM_HR/ALM_MIN.
ss_bcd  out  8  seconds in BCD; reads 00 in ALM states.
mode  out  3  current mode encoding (package enum).
tick_1hz  out  1  one-cycle pulse per second.
alarm_active  out  1  high while ringing.
buzz  out  1  tone output; low when not ringing.

Behaviour:
- Reset (asynchronous, any time): prescaler=0, time=00:00:00, alarm=00:00, mode=RUN, alarm_active=0, buzz=0, tick_1hz=0, tone counter=0. All outputs are registered.
- Prescaler: counts 0..CLK_HZ-1 and wraps. tick_1hz is high for exactly the cycle in which the count equals CLK_HZ-1. It runs in every mode.
- Time counting:
  - In RUN, ALM_HR and ALM_MIN, each tick increments seconds 00..59. A carry goes into minutes 00..59, and a carry from minutes goes into hours 00..23.
  - 23:59:59 + tick -> 00:00:00.
  - Each BCD digit never leaves 0..9, and the tens limits are 5 for minutes/seconds and 2 for hours.
- Modes: RUN -> SET_HR -> SET_MIN -> ALM_HR -> ALM_MIN -> RUN, one step per btn_mode pulse.
  - SET_HR/SET_MIN: time is frozen (ticks ignored). btn_inc adds 1 to hours or minutes with wrap (23->00, 59->00) and no carry into the next field.
  - Leaving SET_MIN clears seconds to 00.
  - ALM_HR/ALM_MIN: btn_inc edits the alarm hours or minutes with the same wrap rules; time keeps running.
  - btn_mode and btn_inc in the same cycle: the mode advances and inc is ignored.
- Alarm trigger:
  - Fires in the cycle after the tick that makes the time equal alarm HH:MM with seconds 00, provided alarm_en=1 and mode is RUN, ALM_HR or ALM_MIN.
  - The comparison is made only on tick transitions, so reset, or editing into a match, never triggers it.
- Ringing:
  - alarm_active=1 and the tone counter starts; buzz toggles every half-period.
  - It clears after ALARM_SEC ticks, or in the cycle after any btn_mode/btn_inc pulse, or after alarm_en going low.
  - A button pulse that silences the alarm is consumed: no mode change and no increment.
  - On clear, buzz returns to 0 and the tone counter resets.
- A new trigger while already ringing does not occur, because HH:MM:00 cannot recur within 60 s.

Decomposition:
- Package alarm_pkg:
  - mode enum (RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4).
  - BCD limit constants (59, 23).
  - Function for the tone half-period computation.
- Sub-module bcd_counter, instantiated for seconds, minutes and hours:
  - Parameterised max value.
  - Inputs: inc and clear.
  - Outputs: 8-bit BCD value and carry, where carry = inc while the counter is at max.

Test Plan:
1. Bench parameters CLK_HZ=20, TONE_HZ=5, ALARM_SEC=3; hold rst for 3 cycles -> all outputs 0. tick_1hz pulses at cycles 19, 39, ...; ss_bcd reaches 8'h01 after the first tick.
2. Set time to 23:59 through SET_HR/SET_MIN (23 inc pulses, then 59), return to RUN, run 60 ticks -> reads 8'h00/8'h00/8'h00 after 23:59:59, then ss_bcd=8'h01.
3. Alarm=00:01, alarm_en=1, time 00:00:00 -> alarm_active rises 1 cycle after the 60th tick. buzz toggles every 2 cycles. alarm_active falls after 3 ticks, with buzz=0.
4. While ringing, pulse btn_inc -> alarm_active=0 next cycle; mode stays RUN and time is unchanged. Repeat with alarm_en dropped -> same result.
5. Assert rst mid-ring and mid-SET_MIN -> outputs return to reset values immediately (asynchronous); no trigger follows.
6. Pulse btn_mode and btn_inc in the same cycle in RUN -> mode=SET_HR and hours unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and helpers for the alarm clock time/alarm core.
package alarm_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        ALM_HR  = 3'd3,
        ALM_MIN = 3'd4
    } mode_e;

    // Upper limits of the minute/second and hour fields, already in BCD.
    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    // Buzzer half-period in clock cycles; never below one cycle.
    function automatic int tone_half(input int clk_hz, input int tone_hz);
        int h;
        h = clk_hz / (2 * tone_hz);
        return (h < 1) ? 1 : h;
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_bcd.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_bcd);
        if (v == max_bcd)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_timekeeper_if.sv
// Control inputs and display/buzzer outputs of the time-of-day core.
// The inputs are plain pulses/levels sampled on clk: btn_mode and btn_inc
// count as one event for each cycle they are high, with no ready/ack back;
// all outputs change only on clk edges (or asynchronously on rst).
interface alarm_timekeeper_if;
    logic                btn_mode;
    logic                btn_inc;
    logic                alarm_en;
    logic [7:0]          hh_bcd;
    logic [7:0]          mm_bcd;
    logic [7:0]          ss_bcd;
    alarm_pkg::mode_e    mode;
    logic                tick_1hz;
    logic                alarm_active;
    logic                buzz;

    modport master (
        output btn_mode, btn_inc, alarm_en,
        input  hh_bcd, mm_bcd, ss_bcd, mode, tick_1hz, alarm_active, buzz
    );

    modport slave (
        input  btn_mode, btn_inc, alarm_en,
        output hh_bcd, mm_bcd, ss_bcd, mode, tick_1hz, alarm_active, buzz
    );
endinterface

// File: rtl/bcd_counter.sv
// Two-digit BCD counter with wrap at MAX_BCD; carry flags the wrapping increment.
module bcd_counter
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = BCD_MAX_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value == MAX_BCD);

    // Clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= 8'h00;
        else if (clear)
            value <= 8'h00;
        else if (inc)
            value <= bcd_inc(value, MAX_BCD);
    end

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day and alarm core: 1 Hz prescaler, BCD HH:MM:SS, HH:MM alarm and buzzer tone.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TONE_HZ   = 2000,
    parameter int ALARM_SEC = 60
) (
    input  logic                clk,
    input  logic                rst,
    alarm_timekeeper_if.slave   bus
);

    localparam int HALF = tone_half(CLK_HZ, TONE_HZ);
    localparam int PW   = $clog2(CLK_HZ);
    localparam int TW   = $clog2(HALF + 1);
    localparam int RW   = $clog2(ALARM_SEC + 1);

    logic [PW-1:0] presc;
    logic          tick_q;
    mode_e         mode_q, mode_d;
    logic          ring_q;
    logic [RW-1:0] ring_cnt;
    logic [TW-1:0] tone_cnt;
    logic          buzz_q;

    logic [7:0] t_ss, t_mm, t_hh, a_mm, a_hh;
    logic       sec_carry, min_carry;
    logic       unused_hr_carry, unused_amm_carry, unused_ahh_carry;

    // A button pulse during ringing only silences; it never edits or steps the mode.
    logic mode_ev, inc_ev, counting, alm_view, trigger, ring_clr;
    logic [7:0] next_mm, next_hh;

    assign mode_ev  = bus.btn_mode && !ring_q;
    assign inc_ev   = bus.btn_inc && !bus.btn_mode && !ring_q;
    assign counting = (mode_q == RUN) || (mode_q == ALM_HR) || (mode_q == ALM_MIN);
    assign alm_view = (mode_q == ALM_HR) || (mode_q == ALM_MIN);

    // Prescaler and registered tick: tick_q is high while presc sits at CLK_HZ-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= (presc == PW'(CLK_HZ - 1)) ? '0 : presc + 1'b1;
            tick_q <= (presc == PW'(CLK_HZ - 2));
        end
    end

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_q <= RUN;
        else
            mode_q <= mode_d;
    end

    // Mode next-state: one step around the ring per accepted btn_mode pulse.
    always_comb begin
        mode_d = mode_q;
        if (mode_ev) begin
            case (mode_q)
                RUN:     mode_d = SET_HR;
                SET_HR:  mode_d = SET_MIN;
                SET_MIN: mode_d = ALM_HR;
                ALM_HR:  mode_d = ALM_MIN;
                ALM_MIN: mode_d = RUN;
                default: mode_d = RUN;
            endcase
        end
    end

    bcd_counter #(.MAX_BCD(BCD_MAX_MS)) u_sec (
        .clk(clk), .rst(rst),
        .inc(tick_q && counting),
        .clear(mode_ev && (mode_q == SET_MIN)),
        .value(t_ss), .carry(sec_carry)
    );

    bcd_counter #(.MAX_BCD(BCD_MAX_MS)) u_min (
        .clk(clk), .rst(rst),
        .inc(sec_carry || (inc_ev && (mode_q == SET_MIN))),
        .clear(1'b0),
        .value(t_mm), .carry(min_carry)
    );

    // Hour carry-in only from running time; a minute edit wrap must not bump hours.
    bcd_counter #(.MAX_BCD(BCD_MAX_HR)) u_hr (
        .clk(clk), .rst(rst),
        .inc((min_carry && counting) || (inc_ev && (mode_q == SET_HR))),
        .clear(1'b0),
        .value(t_hh), .carry(unused_hr_carry)
    );

    bcd_counter #(.MAX_BCD(BCD_MAX_MS)) u_alm_min (
        .clk(clk), .rst(rst),
        .inc(inc_ev && (mode_q == ALM_MIN)),
        .clear(1'b0),
        .value(a_mm), .carry(unused_amm_carry)
    );

    bcd_counter #(.MAX_BCD(BCD_MAX_HR)) u_alm_hr (
        .clk(clk), .rst(rst),
        .inc(inc_ev && (mode_q == ALM_HR)),
        .clear(1'b0),
        .value(a_hh), .carry(unused_ahh_carry)
    );

    // Look ahead at the HH:MM the seconds wrap is about to produce, so the
    // alarm rises in the very cycle the new time becomes visible.
    assign next_mm  = bcd_inc(t_mm, BCD_MAX_MS);
    assign next_hh  = (t_mm == BCD_MAX_MS) ? bcd_inc(t_hh, BCD_MAX_HR) : t_hh;
    assign trigger  = sec_carry && bus.alarm_en && !ring_q &&
                      (next_mm == a_mm) && (next_hh == a_hh);
    assign ring_clr = ring_q && (bus.btn_mode || bus.btn_inc || !bus.alarm_en ||
                      (tick_q && (ring_cnt == RW'(ALARM_SEC - 1))));

    // Ringing state and count of seconds rung so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q   <= 1'b0;
            ring_cnt <= '0;
        end else if (ring_clr) begin
            ring_q   <= 1'b0;
            ring_cnt <= '0;
        end else if (trigger) begin
            ring_q   <= 1'b1;
            ring_cnt <= '0;
        end else if (ring_q && tick_q) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end

    // Square tone while ringing; held at zero otherwise and on the clearing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!ring_q || ring_clr) begin
            tone_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (tone_cnt == TW'(HALF - 1)) begin
            tone_cnt <= '0;
            buzz_q   <= ~buzz_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign bus.hh_bcd       = alm_view ? a_hh : t_hh;
    assign bus.mm_bcd       = alm_view ? a_mm : t_mm;
    assign bus.ss_bcd       = alm_view ? 8'h00 : t_ss;
    assign bus.mode         = mode_q;
    assign bus.tick_1hz     = tick_q;
    assign bus.alarm_active = ring_q;
    assign bus.buzz         = buzz_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Self-checking bench for alarm_timekeeper against a seconds-of-day reference model.
module tb_alarm_timekeeper;

    localparam int CLK_HZ    = 20;
    localparam int TONE_HZ   = 5;
    localparam int ALARM_SEC = 3;
    localparam int HALF      = CLK_HZ / (2 * TONE_HZ);

    logic clk = 1'b0;
    logic rst = 1'b1;

    alarm_timekeeper_if bus();

    alarm_timekeeper #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: time as seconds of day, alarm as minutes of day
    int  tod_m, alm_m, mode_m, ring_ticks_m, ring_k_m, cyc_m;
    bit  ring_m;
    logic [29:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    function automatic logic [29:0] exp_vec();
        logic [7:0] h, m, s;
        logic       tk, bz;
        bit         av;
        av = (mode_m == 3) || (mode_m == 4);
        h  = av ? to_bcd(alm_m / 60) : to_bcd(tod_m / 3600);
        m  = av ? to_bcd(alm_m % 60) : to_bcd((tod_m / 60) % 60);
        s  = av ? 8'h00 : to_bcd(tod_m % 60);
        tk = ((cyc_m % CLK_HZ) == CLK_HZ - 1);
        bz = ring_m ? (((ring_k_m / HALF) % 2) == 1) : 1'b0;
        return {h, m, s, 3'(mode_m), tk, ring_m, bz};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd, bus.mode,
                bus.tick_1hz, bus.alarm_active, bus.buzz};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        tod_m = 0; alm_m = 0; mode_m = 0;
        ring_m = 0; ring_ticks_m = 0; ring_k_m = 0; cyc_m = 0;
        exp_q.delete();
        exp_q.push_back(exp_vec());
    endtask

    // One clock edge of the model, given the inputs held during the cycle.
    task automatic model_edge(input bit bm, input bit bi, input bit en);
        bit tick, counting, was_ring;
        int h, m, s, alm_old;
        tick     = ((cyc_m % CLK_HZ) == CLK_HZ - 1);
        counting = (mode_m == 0) || (mode_m == 3) || (mode_m == 4);
        was_ring = ring_m;
        alm_old  = alm_m;
        h = tod_m / 3600; m = (tod_m / 60) % 60; s = tod_m % 60;
        if (was_ring) begin
            ring_k_m++;
            if (bm || bi || !en)
                ring_m = 0;
            else if (tick) begin
                ring_ticks_m++;
                if (ring_ticks_m == ALARM_SEC) ring_m = 0;
            end
        end else if (bm) begin
            if (mode_m == 2) s = 0;
            mode_m = (mode_m + 1) % 5;
        end else if (bi) begin
            case (mode_m)
                1: h = (h + 1) % 24;
                2: m = (m + 1) % 60;
                3: alm_m = ((alm_m / 60 + 1) % 24) * 60 + alm_m % 60;
                4: alm_m = (alm_m / 60) * 60 + (alm_m % 60 + 1) % 60;
                default: ;
            endcase
        end
        tod_m = h * 3600 + m * 60 + s;
        if (tick && counting) tod_m = (tod_m + 1) % 86400;
        if (!was_ring && tick && counting && en && (tod_m == alm_old * 60)) begin
            ring_m = 1; ring_ticks_m = 0; ring_k_m = 0;
        end
        cyc_m++;
        exp_q.push_back(exp_vec());
    endtask

    // driver: called at a negedge; compares, drives one cycle, returns at next negedge
    task automatic step(input bit bm, input bit bi);
        logic [29:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("outs", {2'b00, dut_vec()}, {2'b00, e});
        end
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        @(posedge clk);
        model_edge(bm, bi, bus.alarm_en);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic run_until_ring(input bit lvl, input int budget);
        int n;
        n = 0;
        while ((ring_m != lvl) && (n < budget)) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("ring_level", {31'd0, bus.alarm_active}, {31'd0, lvl});
    endtask

    // RUN -> ... -> ALM_MIN, one alarm-minute increment, back to RUN
    task automatic bump_alarm_min();
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1 check("async_rst", {2'b00, dut_vec()}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        bit bm, bi;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.alarm_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", {2'b00, dut_vec()}, 32'd0);
        rst = 1'b0;

        // first tick lands in cycle 19
        repeat (19) step(1'b0, 1'b0);
        check("tick_19", {31'd0, bus.tick_1hz}, 32'd1);
        step(1'b0, 1'b0);
        check("ss_first", {24'd0, bus.ss_bcd}, 32'h01);

        // set 23:59 and roll over midnight
        step(1'b1, 1'b0);
        repeat (23) step(1'b0, 1'b1);
        check("set_hh", {24'd0, bus.hh_bcd}, 32'h23);
        step(1'b1, 1'b0);
        repeat (59) step(1'b0, 1'b1);
        check("set_mm", {24'd0, bus.mm_bcd}, 32'h59);
        repeat (3) step(1'b1, 1'b0);
        check("back_run", {29'd0, bus.mode}, 32'd0);
        check("sec_clr", {24'd0, bus.ss_bcd}, 32'h00);
        n = 0;
        while ((tod_m != 0) && (n < 2000)) begin step(1'b0, 1'b0); n++; end
        check("midnight", {8'd0, bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 32'h000000);
        n = 0;
        while ((tod_m != 1) && (n < 100)) begin step(1'b0, 1'b0); n++; end
        check("after_mid", {24'd0, bus.ss_bcd}, 32'h01);

        // alarm 00:01, ring for ALARM_SEC ticks
        bus.alarm_en = 1'b1;
        bump_alarm_min();
        check("time_zero", {8'd0, bus.hh_bcd, bus.mm_bcd, bus.ss_bcd}, 32'h000000);
        run_until_ring(1'b1, 1400);
        check("ring_mm", {24'd0, bus.mm_bcd}, 32'h01);
        run_until_ring(1'b0, 200);
        check("ring_end_buzz", {31'd0, bus.buzz}, 32'd0);

        // silence by btn_inc
        bump_alarm_min();
        run_until_ring(1'b1, 1400);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("sil_inc", {31'd0, bus.alarm_active}, 32'd0);
        check("sil_mode", {29'd0, bus.mode}, 32'd0);
        check("sil_buzz", {31'd0, bus.buzz}, 32'd0);

        // silence by alarm_en low
        bump_alarm_min();
        run_until_ring(1'b1, 1400);
        repeat (3) step(1'b0, 1'b0);
        bus.alarm_en = 1'b0;
        step(1'b0, 1'b0);
        check("sil_en", {31'd0, bus.alarm_active}, 32'd0);
        bus.alarm_en = 1'b1;

        // asynchronous reset mid-ring and mid-SET_MIN
        bump_alarm_min();
        run_until_ring(1'b1, 1400);
        repeat (7) step(1'b0, 1'b0);
        async_reset();
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        async_reset();
        repeat (100) step(1'b0, 1'b0);
        check("no_trig", {31'd0, bus.alarm_active}, 32'd0);

        // mode and inc together: mode wins
        step(1'b1, 1'b1);
        check("both_mode", {29'd0, bus.mode}, 32'd1);
        check("both_hh", {24'd0, bus.hh_bcd}, 32'h00);
        repeat (4) step(1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 59);
            bm = (r == 0);
            bi = (r == 1) || (r == 2);
            if ($urandom_range(0, 399) == 0) bus.alarm_en = ~bus.alarm_en;
            step(bm, bi);
        end
        step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
